// File: rtl/simon_round_ctrl.sv
// Simon round controller: plays back the stored sequence on the key LEDs, then scores player presses.
// Optional input timeout in INPUT is compiled in when SIMON_TIMEOUT_EN is defined.
module simon_round_ctrl #(
    parameter int NUM_KEYS   = 4,
    parameter int MAX_ROUNDS = 100,
    parameter int SHOW_TICKS = 2,
    parameter int GAP_TICKS  = 1,
    parameter int TO_TICKS   = 8,
    localparam int SW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [SW-1:0]       seq_sym,
    output logic                seq_start,
    output logic [6:0]          seq_idx,
    output logic [NUM_KEYS-1:0] key_leds,
    output logic [RW-1:0]       round,
    output logic                game_over,
    output logic                game_win
);

    localparam int IW       = 7;
    localparam int MAX_A    = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_MAX  = (MAX_A > TO_TICKS) ? MAX_A : TO_TICKS;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SHOW,
        S_INPUT,
        S_LOSE,
        S_WIN
    } state_t;

    state_t              state_reg;
    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;
    logic [NUM_KEYS-1:0] key_prev_reg;
    logic [NUM_KEYS-1:0] press_reg;
    logic [NUM_KEYS-1:0] key_leds_reg;
    logic [NUM_KEYS-1:0] sym_onehot;
    logic [IW-1:0]       seq_idx_reg;
    logic [RW-1:0]       round_reg;
    logic [CW-1:0]       tick_cnt_reg;
    logic                seq_start_reg;
    logic                game_over_reg;
    logic                game_win_reg;
    logic                play_done_reg;

    logic any_press;
    logic press_match;
    logic last_sym;
    logic last_round;
    logic gap_done;
    logic show_done;

    // Keys are active-low and asynchronous; flops idle at "released" (all ones).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg    <= '1;
            sync2_reg    <= '1;
            key_prev_reg <= '1;
            press_reg    <= '0;
        end else begin
            sync1_reg    <= key_n;
            sync2_reg    <= sync1_reg;
            key_prev_reg <= sync2_reg;
            press_reg    <= key_prev_reg & ~sync2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_onehot
            assign sym_onehot[gi] = (seq_sym == SW'(gi));
        end
    endgenerate

    // sym_onehot has exactly one bit set, so equality also rejects simultaneous presses.
    assign any_press   = |press_reg;
    assign press_match = (press_reg == sym_onehot);
    assign last_sym    = (seq_idx_reg == (IW'(round_reg) - IW'(1)));
    assign last_round  = (round_reg == RW'(MAX_ROUNDS));
    assign gap_done    = tick && (tick_cnt_reg == CW'(GAP_TICKS - 1));
    assign show_done   = tick && (tick_cnt_reg == CW'(SHOW_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            key_leds_reg  <= '0;
            round_reg     <= '0;
            seq_idx_reg   <= '0;
            tick_cnt_reg  <= '0;
            seq_start_reg <= 1'b0;
            game_over_reg <= 1'b0;
            game_win_reg  <= 1'b0;
            play_done_reg <= 1'b0;
        end else begin
            seq_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    key_leds_reg <= '0;
                    if (any_press) begin
                        seq_start_reg <= 1'b1;
                        round_reg     <= RW'(1);
                        seq_idx_reg   <= '0;
                        play_done_reg <= 1'b0;
                        tick_cnt_reg  <= '0;
                        state_reg     <= S_GAP;
                    end
                end
                S_GAP: begin
                    key_leds_reg <= '0;
                    if (gap_done) begin
                        tick_cnt_reg <= '0;
                        if (play_done_reg) begin
                            seq_idx_reg <= '0;
                            state_reg   <= S_INPUT;
                        end else begin
                            key_leds_reg <= sym_onehot;
                            state_reg    <= S_SHOW;
                        end
                    end else if (tick) begin
                        tick_cnt_reg <= tick_cnt_reg + CW'(1);
                    end
                end
                S_SHOW: begin
                    key_leds_reg <= sym_onehot;
                    if (show_done) begin
                        tick_cnt_reg <= '0;
                        key_leds_reg <= '0;
                        state_reg    <= S_GAP;
                        // Last symbol: index parks at 0 rather than reaching round.
                        if (last_sym) begin
                            play_done_reg <= 1'b1;
                            seq_idx_reg   <= '0;
                        end else begin
                            seq_idx_reg <= seq_idx_reg + IW'(1);
                        end
                    end else if (tick) begin
                        tick_cnt_reg <= tick_cnt_reg + CW'(1);
                    end
                end
                S_INPUT: begin
                    key_leds_reg <= ~sync2_reg;
                    if (any_press) begin
                        tick_cnt_reg <= '0;
                        if (!press_match) begin
                            game_over_reg <= 1'b1;
                            key_leds_reg  <= '1;
                            state_reg     <= S_LOSE;
                        end else if (!last_sym) begin
                            seq_idx_reg <= seq_idx_reg + IW'(1);
                        end else if (last_round) begin
                            game_win_reg <= 1'b1;
                            key_leds_reg <= '1;
                            state_reg    <= S_WIN;
                        end else begin
                            round_reg     <= round_reg + RW'(1);
                            seq_idx_reg   <= '0;
                            play_done_reg <= 1'b0;
                            key_leds_reg  <= '0;
                            state_reg     <= S_GAP;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (tick) begin
                        if (tick_cnt_reg == CW'(TO_TICKS - 1)) begin
                            tick_cnt_reg  <= '0;
                            game_over_reg <= 1'b1;
                            key_leds_reg  <= '1;
                            state_reg     <= S_LOSE;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + CW'(1);
                        end
                    end
`else
                    else begin
                        tick_cnt_reg <= '0;
                    end
`endif
                end
                S_LOSE, S_WIN: begin
                    if (any_press) begin
                        state_reg     <= S_IDLE;
                        key_leds_reg  <= '0;
                        round_reg     <= '0;
                        seq_idx_reg   <= '0;
                        tick_cnt_reg  <= '0;
                        game_over_reg <= 1'b0;
                        game_win_reg  <= 1'b0;
                        play_done_reg <= 1'b0;
                    end else if (state_reg == S_WIN) begin
                        key_leds_reg <= '1;
                    end else if (tick) begin
                        key_leds_reg <= ~key_leds_reg;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign seq_start = seq_start_reg;
    assign seq_idx   = seq_idx_reg;
    assign key_leds  = key_leds_reg;
    assign round     = round_reg;
    assign game_over = game_over_reg;
    assign game_win  = game_win_reg;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: 4 keys, 3 rounds, sequence {2,0,3}, tick every clk.
module tb_simon_round_ctrl;

    localparam int NUM_KEYS   = 4;
    localparam int MAX_ROUNDS = 3;
    localparam int SHOW_TICKS = 2;
    localparam int GAP_TICKS  = 1;
    localparam int TO_TICKS   = 8;

    typedef struct {
        int rnd;
        int over;
        int win;
    } resp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] key_n;
    logic [1:0] seq_sym;
    logic       seq_start;
    logic [6:0] seq_idx;
    logic [3:0] key_leds;
    logic [1:0] round;
    logic       game_over;
    logic       game_win;

    logic [1:0] seq_mem [0:2];
    resp_t      resp_q[$];
    int         play_q[$];
    int         total = 0;
    int         bad = 0;
    int         start_cnt = 0;

    simon_round_ctrl #(
        .NUM_KEYS  (NUM_KEYS),
        .MAX_ROUNDS(MAX_ROUNDS),
        .SHOW_TICKS(SHOW_TICKS),
        .GAP_TICKS (GAP_TICKS),
        .TO_TICKS  (TO_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .key_n    (key_n),
        .seq_sym  (seq_sym),
        .seq_start(seq_start),
        .seq_idx  (seq_idx),
        .key_leds (key_leds),
        .round    (round),
        .game_over(game_over),
        .game_win (game_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        seq_mem[0] = 2'd2;
        seq_mem[1] = 2'd0;
        seq_mem[2] = 2'd3;
    end

    always_comb begin
        seq_sym = 2'd0;
        if (seq_idx < 7'd3) seq_sym = seq_mem[seq_idx[1:0]];
    end

    always @(posedge clk) if (seq_start) start_cnt <= start_cnt + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive a one-clk press (mask = keys held), then score the DUT reaction 4 clk later.
    task automatic do_press(input logic [3:0] mask, input int rnd, input int over,
                            input int win, input bit echo);
        resp_t e;
        resp_t r;
        e.rnd = rnd;
        e.over = over;
        e.win = win;
        resp_q.push_back(e);
        key_n = ~mask;
        @(negedge clk);
        key_n = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        if (echo) check_val("echo", int'(key_leds), int'(mask));
        @(negedge clk);
        r = resp_q.pop_front();
        check_val("round", int'(round), r.rnd);
        check_val("game_over", int'(game_over), r.over);
        check_val("game_win", int'(game_win), r.win);
        $display("press mask=%b round=%0d over=%0d win=%0d leds=%b",
                 mask, round, game_over, game_win, key_leds);
    endtask

    // Expect n playback symbols; optionally press key3 during the first one.
    task automatic expect_play(input int n, input bit inject);
        int w;
        int d;
        int e;
        for (int i = 0; i < n; i++) play_q.push_back(1 << seq_mem[i]);
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (key_leds == 4'b0000 && w < 20) begin
                @(negedge clk);
                w++;
            end
            e = play_q.pop_front();
            check_val($sformatf("play%0d", i), int'(key_leds), e);
            if (inject && i == 0) key_n = 4'b0111;
            d = 0;
            while (key_leds != 4'b0000 && d < 10) begin
                @(negedge clk);
                d++;
                if (inject && i == 0 && d == 1) key_n = 4'b1111;
            end
            check_val("show_len", d, SHOW_TICKS);
            $display("play sym%0d leds=%b len=%0d", i, e[3:0], d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        tick = 1'b1;
        key_n = 4'b1111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_leds", int'(key_leds), 0);
        check_val("rst_round", int'(round), 0);
        check_val("rst_idx", int'(seq_idx), 0);
        check_val("rst_start", int'(seq_start), 0);
        check_val("rst_over", int'(game_over), 0);
        check_val("rst_win", int'(game_win), 0);

        // Full winning game
        do_press(4'b0010, 1, 0, 0, 1'b0);
        check_val("start_pulse", int'(seq_start), 1);
        expect_play(1, 1'b0);
        check_val("start_once", start_cnt, 1);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        expect_play(2, 1'b0);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        do_press(4'b0001, 3, 0, 0, 1'b1);
        expect_play(3, 1'b0);
        do_press(4'b0100, 3, 0, 0, 1'b1);
        do_press(4'b0001, 3, 0, 0, 1'b1);
        do_press(4'b1000, 3, 0, 1, 1'b1);
        check_val("win_leds", int'(key_leds), 15);
        do_press(4'b0001, 0, 0, 0, 1'b0);
        check_val("idle_leds", int'(key_leds), 0);

        // Wrong key in round 2
        do_press(4'b1000, 1, 0, 0, 1'b0);
        expect_play(1, 1'b0);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        expect_play(2, 1'b0);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        do_press(4'b1000, 2, 1, 0, 1'b1);
        check_val("lose_leds0", int'(key_leds), 15);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("lose_leds%0d", i), int'(key_leds), (i % 2) ? 0 : 15);
        end
        do_press(4'b0010, 0, 0, 0, 1'b0);

        // Reset during playback
        do_press(4'b0010, 1, 0, 0, 1'b0);
        w = 0;
        while (key_leds == 4'b0000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val("mid_show", int'(key_leds), 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("mrst_leds", int'(key_leds), 0);
        check_val("mrst_round", int'(round), 0);
        check_val("mrst_idx", int'(seq_idx), 0);
        check_val("mrst_flags", int'({game_over, game_win}), 0);

        // Simultaneous presses
        do_press(4'b0010, 1, 0, 0, 1'b0);
        expect_play(1, 1'b0);
        do_press(4'b0101, 1, 1, 0, 1'b1);
        do_press(4'b0001, 0, 0, 0, 1'b0);

        // Press during playback is discarded
        do_press(4'b0001, 1, 0, 0, 1'b0);
        expect_play(1, 1'b0);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        expect_play(2, 1'b1);
        do_press(4'b0100, 2, 0, 0, 1'b1);
        do_press(4'b0001, 3, 0, 0, 1'b1);
        expect_play(3, 1'b0);
        do_press(4'b0010, 3, 1, 0, 1'b1);
        do_press(4'b0001, 0, 0, 0, 1'b0);

        // Idle INPUT behaviour
        do_press(4'b0010, 1, 0, 0, 1'b0);
        expect_play(1, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        repeat (TO_TICKS) @(negedge clk);
        check_val("to_early", int'(game_over), 0);
        @(negedge clk);
        check_val("to_lose", int'(game_over), 1);
        do_press(4'b0001, 0, 0, 0, 1'b0);
`else
        repeat (50) @(negedge clk);
        check_val("wait_over", int'(game_over), 0);
        check_val("wait_win", int'(game_win), 0);
        check_val("wait_round", int'(round), 1);
        do_press(4'b0100, 2, 0, 0, 1'b1);
`endif
        check_val("start_total", start_cnt, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
